// File: rtl/urisc_io_pkg.sv
// Shared register map for urisc memory-mapped peripherals.
// Offsets, control/status bit indices and default timer base.
package urisc_io_pkg;

  localparam logic [7:0] BASE_ADDR_DEF = 8'hF0;

  localparam logic [1:0] OFS_CTRL   = 2'd0;
  localparam logic [1:0] OFS_RELOAD = 2'd1;
  localparam logic [1:0] OFS_COUNT  = 2'd2;
  localparam logic [1:0] OFS_STATUS = 2'd3;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;

  localparam int STAT_EXP = 0;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: one-cycle tick every PRESCALE cycles while en is high.
// Held at zero while disabled, so enabling restarts a full period.
module tick_gen #(
  parameter int PRESCALE   = 50000,
  parameter int PRESCALE_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam logic [PRESCALE_W-1:0] LAST =
    PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] r_cnt;

  assign tick = en & (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset | ~en) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// Bus responder: 4-register down-counter timer at BASE_ADDR, mem elsewhere.
// Define MMIO_TIMER_IRQ_EN to add CTRL.IE and the registered irq output.
module mmio_timer
  import urisc_io_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR  = BASE_ADDR_DEF,
  parameter int         PRESCALE   = 50000,
  parameter int         PRESCALE_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] addr,
  input  logic [7:0] cpu_wdata,
  input  logic       we,
  input  logic [7:0] mem_rdata,
  output logic       mem_we,
  output logic [7:0] cpu_rdata
`ifdef MMIO_TIMER_IRQ_EN
  ,
  output logic       irq
`endif
);

  logic       r_en;
  logic       r_auto;
  logic [7:0] r_reload;
  logic [7:0] r_count;
  logic       r_exp;
  logic       r_hit_q;
  logic [7:0] r_rdata_q;

  logic       w_hit;
  logic       w_sel_ctrl;
  logic       w_sel_rel;
  logic       w_sel_cnt;
  logic       w_sel_stat;
  logic       w_wr_ctrl;
  logic       w_wr_rel;
  logic       w_wr_cnt;
  logic       w_wr_stat;
  logic       w_tick;
  logic       w_expire;
  logic       w_ie;
  logic [7:0] w_count_nxt;
  logic [7:0] w_ctrl;
  logic [7:0] w_stat;
  logic [7:0] w_rmux;

  assign w_hit  = (addr[7:2] == BASE_ADDR[7:2]);
  assign mem_we = we & ~w_hit;

  assign w_sel_ctrl = (addr[1:0] == OFS_CTRL);
  assign w_sel_rel  = (addr[1:0] == OFS_RELOAD);
  assign w_sel_cnt  = (addr[1:0] == OFS_COUNT);
  assign w_sel_stat = (addr[1:0] == OFS_STATUS);

  assign w_wr_ctrl = we & w_hit & w_sel_ctrl;
  assign w_wr_rel  = we & w_hit & w_sel_rel;
  assign w_wr_cnt  = we & w_hit & w_sel_cnt;
  assign w_wr_stat = we & w_hit & w_sel_stat;

  tick_gen #(
    .PRESCALE   (PRESCALE),
    .PRESCALE_W (PRESCALE_W)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (r_en),
    .tick  (w_tick)
  );

  // A COUNT write in the tick cycle swallows the tick, expiry included.
  assign w_expire = w_tick & (r_count == 8'd1) & ~w_wr_cnt;

  always_comb begin
    w_count_nxt = r_count - 8'd1;
    if (r_count == 8'd0) begin
      w_count_nxt = 8'd0;
    end else if (r_count == 8'd1) begin
      w_count_nxt = r_auto ? r_reload : 8'd0;
    end
  end

`ifdef MMIO_TIMER_IRQ_EN
  logic r_ie;
  logic r_irq;

  assign w_ie = r_ie;
  assign irq  = r_irq;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ie  <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_ie <= cpu_wdata[CTRL_IE];
      end
      r_irq <= r_exp & r_ie;
    end
  end
`else
  assign w_ie = 1'b0;
`endif

  always_comb begin
    w_ctrl            = '0;
    w_ctrl[CTRL_EN]   = r_en;
    w_ctrl[CTRL_AUTO] = r_auto;
    w_ctrl[CTRL_IE]   = w_ie;
    w_stat            = '0;
    w_stat[STAT_EXP]  = r_exp;
  end

  always_comb begin
    w_rmux = '0;
    unique case (1'b1)
      w_sel_ctrl: w_rmux = w_ctrl;
      w_sel_rel:  w_rmux = r_reload;
      w_sel_cnt:  w_rmux = r_count;
      w_sel_stat: w_rmux = w_stat;
      default:    w_rmux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_en      <= 1'b0;
      r_auto    <= 1'b0;
      r_reload  <= '0;
      r_count   <= '0;
      r_exp     <= 1'b0;
      r_hit_q   <= 1'b0;
      r_rdata_q <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_en   <= cpu_wdata[CTRL_EN];
        r_auto <= cpu_wdata[CTRL_AUTO];
      end else if (w_expire & ~r_auto) begin
        r_en <= 1'b0;
      end
      if (w_wr_rel) begin
        r_reload <= cpu_wdata;
      end
      if (w_wr_cnt) begin
        r_count <= cpu_wdata;
      end else if (w_tick) begin
        r_count <= w_count_nxt;
      end
      if (w_expire) begin
        r_exp <= 1'b1;
      end else if (w_wr_stat & cpu_wdata[STAT_EXP]) begin
        r_exp <= 1'b0;
      end
      r_hit_q   <= w_hit;
      r_rdata_q <= w_rmux;
    end
  end

  assign cpu_rdata = r_hit_q ? r_rdata_q : mem_rdata;

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer with PRESCALE=4 and a simple mem model.
// Define MMIO_TIMER_IRQ_EN to also exercise the irq output.
module tb_mmio_timer;

  localparam logic [7:0] A_CTRL = 8'hF0;
  localparam logic [7:0] A_REL  = 8'hF1;
  localparam logic [7:0] A_CNT  = 8'hF2;
  localparam logic [7:0] A_STAT = 8'hF3;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] addr;
  logic [7:0] cpu_wdata;
  logic       we;
  logic [7:0] mem_rdata;
  logic       mem_we;
  logic [7:0] cpu_rdata;
`ifdef MMIO_TIMER_IRQ_EN
  logic       irq;
`endif

  int pass_n = 0;
  int tot_n  = 0;
  int cycn   = 0;

  logic [7:0] mem [256] = '{default: 8'hE7};

  mmio_timer #(
    .BASE_ADDR  (8'hF0),
    .PRESCALE   (4),
    .PRESCALE_W (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .cpu_wdata (cpu_wdata),
    .we        (we),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .cpu_rdata (cpu_rdata)
`ifdef MMIO_TIMER_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycn <= cycn + 1;
    if (mem_we) mem[addr] <= cpu_wdata;
    mem_rdata <= mem[addr];
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr = a;
    cpu_wdata = d;
    we = 1'b1;
    cyc();
    we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    addr = a;
    we = 1'b0;
    cyc();
    d = cpu_rdata;
  endtask

  task automatic upto(input int e);
    while (cycn < e - 1) cyc();
  endtask

  task automatic rd_at(input logic [7:0] a, input int e,
                       output logic [7:0] d);
    upto(e);
    rd(a, d);
  endtask

  task automatic quiesce();
    wr(A_CTRL, 8'h00);
    wr(A_STAT, 8'h01);
    wr(A_CNT, 8'h00);
    wr(A_REL, 8'h00);
  endtask

  task automatic test_reset();
    logic [7:0] d;
    reset = 1'b1;
    addr = 8'h00;
    cpu_wdata = 8'h00;
    we = 1'b0;
    cyc();
    cyc();
    addr = 8'h20;
    we = 1'b1;
    #1;
    tot_n++;
    if (mem_we !== 1'b1) $display("FAIL rst_mem_we got %b exp 1", mem_we);
    else pass_n++;
    addr = A_CTRL;
    #1;
    tot_n++;
    if (mem_we !== 1'b0) $display("FAIL rst_gate got %b exp 0", mem_we);
    else pass_n++;
    we = 1'b0;
    cyc();
    reset = 1'b0;
    rd(8'h30, d);
    tot_n++;
    if (d !== 8'hE7) $display("FAIL rst_pass got %h exp e7", d);
    else pass_n++;
    for (int i = 0; i < 4; i++) begin
      rd(A_CTRL + 8'(i), d);
      tot_n++;
      if (d !== 8'h00) $display("FAIL rst_reg%0d got %h exp 00", i, d);
      else pass_n++;
    end
`ifdef MMIO_TIMER_IRQ_EN
    tot_n++;
    if (irq !== 1'b0) $display("FAIL rst_irq got %b exp 0", irq);
    else pass_n++;
`endif
  endtask

  task automatic test_passthru();
    logic [7:0] d;
    addr = 8'h10;
    cpu_wdata = 8'h5A;
    we = 1'b1;
    #1;
    tot_n++;
    if (mem_we !== 1'b1) $display("FAIL pt_we got %b exp 1", mem_we);
    else pass_n++;
    cyc();
    we = 1'b0;
    rd(8'h10, d);
    tot_n++;
    if (d !== 8'h5A) $display("FAIL pt_rd got %h exp 5a", d);
    else pass_n++;
    addr = A_REL;
    cpu_wdata = 8'h3C;
    we = 1'b1;
    #1;
    tot_n++;
    if (mem_we !== 1'b0) $display("FAIL pt_win_we got %b exp 0", mem_we);
    else pass_n++;
    cyc();
    we = 1'b0;
    tot_n++;
    if (mem[8'hF1] !== 8'hE7) $display("FAIL pt_mem got %h exp e7", mem[8'hF1]);
    else pass_n++;
    rd(A_REL, d);
    tot_n++;
    if (d !== 8'h3C) $display("FAIL pt_reload got %h exp 3c", d);
    else pass_n++;
  endtask

  task automatic test_oneshot();
    logic [7:0] d;
    int e0;
    quiesce();
    wr(A_CNT, 8'h03);
    wr(A_CTRL, 8'h01);
    e0 = cycn;
    rd_at(A_CNT, e0 + 4, d);
    tot_n++;
    if (d !== 8'h03) $display("FAIL os_old got %h exp 03", d);
    else pass_n++;
    rd_at(A_CNT, e0 + 5, d);
    tot_n++;
    if (d !== 8'h02) $display("FAIL os_t1 got %h exp 02", d);
    else pass_n++;
    rd_at(A_CNT, e0 + 9, d);
    tot_n++;
    if (d !== 8'h01) $display("FAIL os_t2 got %h exp 01", d);
    else pass_n++;
    rd_at(A_CNT, e0 + 13, d);
    tot_n++;
    if (d !== 8'h00) $display("FAIL os_t3 got %h exp 00", d);
    else pass_n++;
    rd_at(A_STAT, e0 + 14, d);
    tot_n++;
    if (d !== 8'h01) $display("FAIL os_exp got %h exp 01", d);
    else pass_n++;
    rd_at(A_CTRL, e0 + 15, d);
    tot_n++;
    if (d !== 8'h00) $display("FAIL os_ctrl got %h exp 00", d);
    else pass_n++;
  endtask

  task automatic test_autoreload();
    logic [7:0] d;
    int e0;
    quiesce();
    wr(A_REL, 8'h02);
    wr(A_CNT, 8'h01);
    wr(A_CTRL, 8'h03);
    e0 = cycn;
    rd_at(A_CNT, e0 + 5, d);
    tot_n++;
    if (d !== 8'h02) $display("FAIL ar_cnt got %h exp 02", d);
    else pass_n++;
    rd_at(A_STAT, e0 + 6, d);
    tot_n++;
    if (d !== 8'h01) $display("FAIL ar_exp1 got %h exp 01", d);
    else pass_n++;
    upto(e0 + 7);
    wr(A_STAT, 8'h01);
    rd_at(A_CNT, e0 + 9, d);
    tot_n++;
    if (d !== 8'h01) $display("FAIL ar_dec got %h exp 01", d);
    else pass_n++;
    rd_at(A_STAT, e0 + 12, d);
    tot_n++;
    if (d !== 8'h00) $display("FAIL ar_clr got %h exp 00", d);
    else pass_n++;
    rd_at(A_STAT, e0 + 13, d);
    tot_n++;
    if (d !== 8'h01) $display("FAIL ar_exp2 got %h exp 01", d);
    else pass_n++;
    rd_at(A_CTRL, e0 + 14, d);
    tot_n++;
    if (d !== 8'h03) $display("FAIL ar_ctrl got %h exp 03", d);
    else pass_n++;
    rd_at(A_CNT, e0 + 15, d);
    tot_n++;
    if (d !== 8'h02) $display("FAIL ar_cnt2 got %h exp 02", d);
    else pass_n++;
  endtask

  task automatic test_reload0();
    logic [7:0] d;
    int e0;
    quiesce();
    wr(A_CNT, 8'h01);
    wr(A_CTRL, 8'h03);
    e0 = cycn;
    rd_at(A_CNT, e0 + 5, d);
    tot_n++;
    if (d !== 8'h00) $display("FAIL r0_cnt got %h exp 00", d);
    else pass_n++;
    rd_at(A_CTRL, e0 + 6, d);
    tot_n++;
    if (d !== 8'h03) $display("FAIL r0_ctrl got %h exp 03", d);
    else pass_n++;
    rd_at(A_STAT, e0 + 7, d);
    tot_n++;
    if (d !== 8'h01) $display("FAIL r0_exp got %h exp 01", d);
    else pass_n++;
  endtask

  task automatic test_collide();
    logic [7:0] d;
    int e0;
    quiesce();
    wr(A_CNT, 8'h05);
    wr(A_CTRL, 8'h01);
    e0 = cycn;
    upto(e0 + 4);
    wr(A_CNT, 8'h09);
    rd_at(A_CNT, e0 + 5, d);
    tot_n++;
    if (d !== 8'h09) $display("FAIL co_cnt got %h exp 09", d);
    else pass_n++;
    rd_at(A_CNT, e0 + 9, d);
    tot_n++;
    if (d !== 8'h08) $display("FAIL co_next got %h exp 08", d);
    else pass_n++;
    upto(e0 + 10);
    wr(A_CNT, 8'h01);
    upto(e0 + 12);
    wr(A_STAT, 8'h01);
    rd_at(A_STAT, e0 + 13, d);
    tot_n++;
    if (d !== 8'h01) $display("FAIL co_exp got %h exp 01", d);
    else pass_n++;
    rd_at(A_CTRL, e0 + 14, d);
    tot_n++;
    if (d !== 8'h00) $display("FAIL co_en got %h exp 00", d);
    else pass_n++;
  endtask

  task automatic test_en_collide();
    logic [7:0] d;
    int e0;
    quiesce();
    wr(A_CNT, 8'h01);
    wr(A_CTRL, 8'h01);
    e0 = cycn;
    upto(e0 + 4);
    wr(A_CTRL, 8'h01);
    rd_at(A_CTRL, e0 + 5, d);
    tot_n++;
    if (d !== 8'h01) $display("FAIL enc_ctrl got %h exp 01", d);
    else pass_n++;
    rd_at(A_STAT, e0 + 6, d);
    tot_n++;
    if (d !== 8'h01) $display("FAIL enc_exp got %h exp 01", d);
    else pass_n++;
  endtask

  task automatic test_ctrl_ie();
    logic [7:0] d;
    logic [7:0] x;
    quiesce();
    wr(A_CTRL, 8'hFE);
    rd(A_CTRL, d);
`ifdef MMIO_TIMER_IRQ_EN
    x = 8'h06;
`else
    x = 8'h02;
`endif
    tot_n++;
    if (d !== x) $display("FAIL ie_bits got %h exp %h", d, x);
    else pass_n++;
    wr(A_CTRL, 8'h00);
  endtask

`ifdef MMIO_TIMER_IRQ_EN
  task automatic test_irq();
    int e0;
    quiesce();
    wr(A_CNT, 8'h01);
    wr(A_CTRL, 8'h05);
    e0 = cycn;
    upto(e0 + 5);
    tot_n++;
    if (irq !== 1'b0) $display("FAIL irq_early got %b exp 0", irq);
    else pass_n++;
    cyc();
    tot_n++;
    if (irq !== 1'b1) $display("FAIL irq_set got %b exp 1", irq);
    else pass_n++;
    wr(A_STAT, 8'h01);
    tot_n++;
    if (irq !== 1'b1) $display("FAIL irq_hold got %b exp 1", irq);
    else pass_n++;
    cyc();
    tot_n++;
    if (irq !== 1'b0) $display("FAIL irq_clr got %b exp 0", irq);
    else pass_n++;
    wr(A_CTRL, 8'h00);
  endtask
`endif

  task automatic test_reset_mid();
    logic [7:0] d;
    quiesce();
    wr(A_CNT, 8'h07);
    wr(A_CTRL, 8'h01);
    cyc();
    cyc();
    addr = A_CNT;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    tot_n++;
    if (cpu_rdata !== 8'hE7) $display("FAIL rm_pass got %h exp e7", cpu_rdata);
    else pass_n++;
    for (int i = 0; i < 4; i++) begin
      rd(A_CTRL + 8'(i), d);
      tot_n++;
      if (d !== 8'h00) $display("FAIL rm_reg%0d got %h exp 00", i, d);
      else pass_n++;
    end
    wr(A_CNT, 8'h03);
    for (int i = 0; i < 6; i++) cyc();
    rd(A_CNT, d);
    tot_n++;
    if (d !== 8'h03) $display("FAIL rm_notick got %h exp 03", d);
    else pass_n++;
  endtask

  initial begin
    test_reset();
    test_passthru();
    test_oneshot();
    test_autoreload();
    test_reload0();
    test_collide();
    test_en_collide();
    test_ctrl_ie();
`ifdef MMIO_TIMER_IRQ_EN
    test_irq();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
